// File: rtl/eq_band_engine_if.sv
// Sample/config/result bundle for the band equaliser.
// The master side (ADC path and config host) drives samples and writes;
// the slave side is the equaliser engine.
interface eq_band_engine_if #(
    parameter int WIDTH  = 23,
    parameter int NBANDS = 3,
    parameter int CAW    = 7
);
    logic                     enable;
    logic [WIDTH-1:0]         uk;
    logic                     coef_we;
    logic [CAW-1:0]           coef_addr;
    logic [WIDTH-1:0]         coef_data;
    logic [WIDTH-1:0]         yk;
    logic [NBANDS*WIDTH-1:0]  yk_bands;
    logic                     out_valid;
    logic                     busy;
    logic                     overrun;
    logic                     cfg_err;

    modport master (
        output enable, uk, coef_we, coef_addr, coef_data,
        input  yk, yk_bands, out_valid, busy, overrun, cfg_err
    );

    modport slave (
        input  enable, uk, coef_we, coef_addr, coef_data,
        output yk, yk_bands, out_valid, busy, overrun, cfg_err
    );
endinterface

// File: rtl/eq_band_engine.sv
// N-band equaliser: per band a low-pass then high-pass biquad, scaled by a
// gain, all bands summed. One shared MAC walks every tap of every section.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for enable; coefficient writes accepted here only
// MAC   | one tap per cycle (tap 0..4) of current band/section
// WB    | saturate section result, shift x/y history of that section
// GAIN  | scale band output by its gain, add into band sum
// DONE  | results registered, out_valid high for this cycle
module eq_band_engine #(
    parameter int p      = 8,
    parameter int f      = 14,
    parameter int Width  = p + f + 1,
    parameter int NBANDS = 3,
    parameter int CAW    = 7
) (
    input  logic            sclk,
    input  logic            rst,
    eq_band_engine_if.slave bus
);

    localparam int NCOEF = 11 * NBANDS;
    localparam int AIW   = $clog2(NCOEF);
    localparam int BIW   = (NBANDS > 1) ? $clog2(NBANDS) : 1;
    localparam int PW    = 2 * Width;
    localparam int AW    = 2 * Width + 3;
    localparam int SW    = Width + 3;

    localparam logic [Width-1:0]     ONE       = Width'(1 << f);
    localparam logic [BIW-1:0]       LAST_BAND = BIW'(NBANDS - 1);
    localparam logic signed [AW-1:0] SAT_HI    = AW'((64'sd1 <<< (Width - 1)) - 64'sd1);
    localparam logic signed [AW-1:0] SAT_LO    = ~SAT_HI;
    localparam logic signed [SW-1:0] SUM_HI    = SW'((64'sd1 <<< (Width - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] SUM_LO    = ~SUM_HI;

    typedef enum logic [2:0] {S_IDLE, S_MAC, S_WB, S_GAIN, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             tap_q, tap_d;
    logic                   sec_q, sec_d;
    logic [BIW-1:0]         band_q, band_d;
    logic [Width-1:0]       uk_q, uk_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic signed [SW-1:0]   sum_q, sum_d;
    logic [Width-1:0]       coef_q [NCOEF];
    logic [Width-1:0]       coef_d [NCOEF];
    logic [Width-1:0]       x1_q [NBANDS][2];
    logic [Width-1:0]       x1_d [NBANDS][2];
    logic [Width-1:0]       x2_q [NBANDS][2];
    logic [Width-1:0]       x2_d [NBANDS][2];
    logic [Width-1:0]       y1_q [NBANDS][2];
    logic [Width-1:0]       y1_d [NBANDS][2];
    logic [Width-1:0]       y2_q [NBANDS][2];
    logic [Width-1:0]       y2_d [NBANDS][2];
    logic [Width-1:0]       gout_q [NBANDS];
    logic [Width-1:0]       gout_d [NBANDS];
    logic [Width-1:0]       ykb_q [NBANDS];
    logic [Width-1:0]       ykb_d [NBANDS];
    logic [Width-1:0]       yk_q, yk_d;
    logic                   overrun_q, overrun_d;
    logic                   cfg_err_q, cfg_err_d;

    logic [AIW-1:0]         rd_idx, gain_idx;
    logic [Width-1:0]       sec_in, opnd, sec_res, gain_res;
    logic signed [SW-1:0]   sum_next;

    // Arithmetic shift by f (floor), then clamp to the Width range.
    function automatic logic [Width-1:0] sat_acc(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] s;
        s = a >>> f;
        if (s > SAT_HI)      sat_acc = SAT_HI[Width-1:0];
        else if (s < SAT_LO) sat_acc = SAT_LO[Width-1:0];
        else                 sat_acc = s[Width-1:0];
    endfunction

    function automatic logic [Width-1:0] sat_sum(input logic signed [SW-1:0] a);
        if (a > SUM_HI)      sat_sum = SUM_HI[Width-1:0];
        else if (a < SUM_LO) sat_sum = SUM_LO[Width-1:0];
        else                 sat_sum = a[Width-1:0];
    endfunction

    // Full-precision signed product, sign-extended to accumulator width.
    function automatic logic signed [AW-1:0] mul_ext(input logic [Width-1:0] a,
                                                     input logic [Width-1:0] b);
        logic signed [PW-1:0] pr;
        pr = $signed({{Width{a[Width-1]}}, a}) * $signed({{Width{b[Width-1]}}, b});
        mul_ext = $signed({{3{pr[PW-1]}}, pr});
    endfunction

    // Operand and coefficient selection for the shared multiplier.
    // Section 1 input is section 0's freshly written y1 of the same band.
    always_comb begin
        rd_idx   = AIW'(11 * int'(band_q) + 5 * int'(sec_q) + int'(tap_q));
        gain_idx = AIW'(11 * int'(band_q) + 10);
        sec_in   = sec_q ? y1_q[band_q][0] : uk_q;
        case (tap_q)
            3'd0:    opnd = sec_in;
            3'd1:    opnd = x1_q[band_q][sec_q];
            3'd2:    opnd = x2_q[band_q][sec_q];
            3'd3:    opnd = y1_q[band_q][sec_q];
            default: opnd = y2_q[band_q][sec_q];
        endcase
        sec_res  = sat_acc(acc_q);
        gain_res = sat_acc(mul_ext(coef_q[gain_idx], y1_q[band_q][1]));
        sum_next = ((band_q == '0) ? '0 : sum_q) + $signed({{3{gain_res[Width-1]}}, gain_res});
    end

    // Sequencer: next state, tap/section/band counters, overrun flag.
    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        sec_d     = sec_q;
        band_d    = band_q;
        uk_d      = uk_q;
        overrun_d = overrun_q;
        if (bus.enable && (state_q != S_IDLE)) overrun_d = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (bus.enable) begin
                    state_d = S_MAC;
                    tap_d   = 3'd0;
                    sec_d   = 1'b0;
                    band_d  = '0;
                    uk_d    = bus.uk;
                end
            end
            S_MAC: begin
                if (tap_q == 3'd4) state_d = S_WB;
                else               tap_d   = tap_q + 3'd1;
            end
            S_WB: begin
                tap_d = 3'd0;
                if (!sec_q) begin
                    sec_d   = 1'b1;
                    state_d = S_MAC;
                end else begin
                    state_d = S_GAIN;
                end
            end
            S_GAIN: begin
                if (band_q == LAST_BAND) begin
                    state_d = S_DONE;
                end else begin
                    band_d  = band_q + BIW'(1);
                    sec_d   = 1'b0;
                    tap_d   = 3'd0;
                    state_d = S_MAC;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: accumulate taps, write back section history, gain and sum.
    always_comb begin
        acc_d  = acc_q;
        sum_d  = sum_q;
        x1_d   = x1_q;
        x2_d   = x2_q;
        y1_d   = y1_q;
        y2_d   = y2_q;
        gout_d = gout_q;
        ykb_d  = ykb_q;
        yk_d   = yk_q;
        case (state_q)
            S_MAC: begin
                acc_d = ((tap_q == 3'd0) ? '0 : acc_q) + mul_ext(coef_q[rd_idx], opnd);
            end
            S_WB: begin
                x2_d[band_q][sec_q] = x1_q[band_q][sec_q];
                x1_d[band_q][sec_q] = sec_in;
                y2_d[band_q][sec_q] = y1_q[band_q][sec_q];
                y1_d[band_q][sec_q] = sec_res;
            end
            S_GAIN: begin
                gout_d[band_q] = gain_res;
                sum_d          = sum_next;
                if (band_q == LAST_BAND) begin
                    for (int b = 0; b < NBANDS; b++) begin
                        ykb_d[b] = (BIW'(b) == band_q) ? gain_res : gout_q[b];
                    end
                    yk_d = sat_sum(sum_next);
                end
            end
            default: ;
        endcase
    end

    // Coefficient register file: writes only land while idle and in range.
    always_comb begin
        coef_d    = coef_q;
        cfg_err_d = cfg_err_q;
        if (bus.coef_we) begin
            if ((state_q != S_IDLE) || (bus.coef_addr >= CAW'(NCOEF))) begin
                cfg_err_d = 1'b1;
            end else begin
                coef_d[bus.coef_addr[AIW-1:0]] = bus.coef_data;
            end
        end
    end

    // State register; reset restores pass-through coefficients and clears history.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            tap_q     <= 3'd0;
            sec_q     <= 1'b0;
            band_q    <= '0;
            uk_q      <= '0;
            acc_q     <= '0;
            sum_q     <= '0;
            yk_q      <= '0;
            overrun_q <= 1'b0;
            cfg_err_q <= 1'b0;
            for (int i = 0; i < NCOEF; i++) begin
                coef_q[i] <= (((i % 11) == 0) || ((i % 11) == 5) || ((i % 11) == 10)) ? ONE : '0;
            end
            for (int b = 0; b < NBANDS; b++) begin
                gout_q[b] <= '0;
                ykb_q[b]  <= '0;
                for (int s = 0; s < 2; s++) begin
                    x1_q[b][s] <= '0;
                    x2_q[b][s] <= '0;
                    y1_q[b][s] <= '0;
                    y2_q[b][s] <= '0;
                end
            end
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            sec_q     <= sec_d;
            band_q    <= band_d;
            uk_q      <= uk_d;
            acc_q     <= acc_d;
            sum_q     <= sum_d;
            yk_q      <= yk_d;
            overrun_q <= overrun_d;
            cfg_err_q <= cfg_err_d;
            coef_q    <= coef_d;
            gout_q    <= gout_d;
            ykb_q     <= ykb_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            y1_q      <= y1_d;
            y2_q      <= y2_d;
        end
    end

    assign bus.yk        = yk_q;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.overrun   = overrun_q;
    assign bus.cfg_err   = cfg_err_q;

    for (genvar g = 0; g < NBANDS; g++) begin : g_bands
        assign bus.yk_bands[g*Width +: Width] = ykb_q[g];
    end

endmodule

// File: tb/tb_eq_band_engine.sv
// Directed bench for eq_band_engine: pass-through, overrun, config guard,
// mid-sample reset, saturation and a 64-sample biquad impulse response.
`timescale 1ns/1ps
module tb_eq_band_engine;
    localparam int W   = 23;
    localparam int NB  = 3;
    localparam int CAW = 7;

    logic sclk = 1'b0;
    logic rst  = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   lat;

    always #5 sclk = ~sclk;

    eq_band_engine_if #(.WIDTH(W), .NBANDS(NB), .CAW(CAW)) bus ();

    eq_band_engine #(.p(8), .f(14), .Width(W), .NBANDS(NB), .CAW(CAW)) dut (
        .sclk (sclk),
        .rst  (rst),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [CAW-1:0] a, input logic [W-1:0] d);
        @(posedge sclk); #1;
        bus.coef_we = 1'b1; bus.coef_addr = a; bus.coef_data = d;
        @(posedge sclk); #1;
        bus.coef_we = 1'b0;
    endtask

    // Called #1 after the edge at offset 'start' from the accepting edge.
    task automatic wait_valid(input int start, output int l);
        l = 0;
        for (int i = start + 1; i <= start + 60; i++) begin
            @(posedge sclk); #1;
            if (bus.out_valid) begin
                l = i;
                break;
            end
        end
        chk("latency", l, 39);
    endtask

    task automatic run_sample(input logic [W-1:0] u, output int l);
        @(posedge sclk); #1;
        bus.enable = 1'b1; bus.uk = u;
        @(posedge sclk); #1;
        bus.enable = 1'b0;
        chk("busy_rise", bus.busy, 1);
        wait_valid(0, l);
    endtask

    task automatic end_sample();
        @(posedge sclk); #1;
        chk("valid_fall", bus.out_valid, 0);
        chk("busy_fall", bus.busy, 0);
    endtask

    initial begin
        longint c [5];
        longint x1, x2, y1, y2, acc, y, u, s;
        logic [W-1:0] exp_y, exp_s;

        bus.enable = 1'b0; bus.uk = '0;
        bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
        repeat (3) @(posedge sclk);
        #1;
        chk("rst_yk", bus.yk, 0);
        chk("rst_bands", bus.yk_bands, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_overrun", bus.overrun, 0);
        chk("rst_cfg_err", bus.cfg_err, 0);
        rst = 1'b1;

        // Default coefficients: every band passes 1.0 straight through.
        run_sample(23'h004000, lat);
        chk("pass_yk", bus.yk, 23'h00C000);
        chk("pass_bands", bus.yk_bands, {3{23'h004000}});
        end_sample();
        chk("pass_hold", bus.yk, 23'h00C000);

        // Second enable five cycles into a sample is ignored.
        @(posedge sclk); #1;
        bus.enable = 1'b1; bus.uk = 23'h002000;
        @(posedge sclk); #1;
        bus.enable = 1'b0;
        chk("ovr_before", bus.overrun, 0);
        repeat (4) begin @(posedge sclk); #1; end
        bus.enable = 1'b1; bus.uk = 23'h001000;
        @(posedge sclk); #1;
        bus.enable = 1'b0;
        chk("ovr_set", bus.overrun, 1);
        wait_valid(5, lat);
        chk("ovr_yk", bus.yk, 23'h006000);
        chk("ovr_bands", bus.yk_bands, {3{23'h002000}});
        end_sample();

        // Gain write to band 1 while busy must be dropped.
        chk("cfg_before", bus.cfg_err, 0);
        @(posedge sclk); #1;
        bus.enable = 1'b1; bus.uk = 23'h004000;
        @(posedge sclk); #1;
        bus.enable = 1'b0;
        @(posedge sclk); #1;
        bus.coef_we = 1'b1; bus.coef_addr = 7'd21; bus.coef_data = 23'h000000;
        @(posedge sclk); #1;
        bus.coef_we = 1'b0;
        chk("cfg_busy_err", bus.cfg_err, 1);
        wait_valid(2, lat);
        chk("cfg_busy_bands", bus.yk_bands, {3{23'h004000}});
        end_sample();
        run_sample(23'h004000, lat);
        chk("cfg_band1_kept", bus.yk_bands[45:23], 23'h004000);
        end_sample();

        // Reset in the middle of a sample.
        @(posedge sclk); #1;
        bus.enable = 1'b1; bus.uk = 23'h003000;
        @(posedge sclk); #1;
        bus.enable = 1'b0;
        repeat (19) begin @(posedge sclk); #1; end
        rst = 1'b0;
        #1;
        chk("mrst_yk", bus.yk, 0);
        chk("mrst_bands", bus.yk_bands, 0);
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_valid", bus.out_valid, 0);
        chk("mrst_overrun", bus.overrun, 0);
        chk("mrst_cfg_err", bus.cfg_err, 0);
        @(posedge sclk); #1;
        rst = 1'b1;
        run_sample(23'h004000, lat);
        chk("mrst_next_yk", bus.yk, 23'h00C000);
        chk("mrst_next_bands", bus.yk_bands, {3{23'h004000}});
        end_sample();

        // Out-of-range address.
        wr(7'd33, 23'h000000);
        chk("addr33_err", bus.cfg_err, 1);

        // Gain write and enable in the same idle cycle: write is used.
        @(posedge sclk); #1;
        bus.coef_we = 1'b1; bus.coef_addr = 7'd10; bus.coef_data = 23'h002000;
        bus.enable = 1'b1; bus.uk = 23'h004000;
        @(posedge sclk); #1;
        bus.coef_we = 1'b0; bus.enable = 1'b0;
        wait_valid(0, lat);
        chk("same_band0", bus.yk_bands[22:0], 23'h002000);
        chk("same_yk", bus.yk, 23'h00A000);
        end_sample();

        // Saturation with band 0 gain of 2.0.
        wr(7'd10, 23'h008000);
        run_sample(23'h3FFFFF, lat);
        chk("satp_bands", bus.yk_bands, {3{23'h3FFFFF}});
        chk("satp_yk", bus.yk, 23'h3FFFFF);
        end_sample();
        run_sample(23'h400000, lat);
        chk("satn_bands", bus.yk_bands, {3{23'h400000}});
        chk("satn_yk", bus.yk, 23'h400000);
        end_sample();

        // Impulse response of a low-pass section against a Q8.14 model.
        rst = 1'b0;
        @(posedge sclk); #1;
        rst = 1'b1;
        wr(7'd0, 23'h000003);
        wr(7'd1, 23'h000007);
        wr(7'd2, 23'h000003);
        wr(7'd3, 23'h007D71);
        wr(7'd4, 23'h7FC287);
        c[0] = 3; c[1] = 7; c[2] = 3; c[3] = 32113; c[4] = -15737;
        x1 = 0; x2 = 0; y1 = 0; y2 = 0;
        for (int n = 0; n < 64; n++) begin
            u   = (n == 0) ? 64'sd16384 : 64'sd0;
            acc = c[0] * u + c[1] * x1 + c[2] * x2 + c[3] * y1 + c[4] * y2;
            y   = acc >>> 14;
            if (y > 4194303) y = 4194303;
            if (y < -4194304) y = -4194304;
            x2 = x1; x1 = u; y2 = y1; y1 = y;
            s = y + 2 * u;
            if (s > 4194303) s = 4194303;
            if (s < -4194304) s = -4194304;
            exp_y = y[W-1:0];
            exp_s = s[W-1:0];
            run_sample(u[W-1:0], lat);
            chk($sformatf("imp_band0[%0d]", n), bus.yk_bands[22:0], exp_y);
            chk($sformatf("imp_yk[%0d]", n), bus.yk, exp_s);
            end_sample();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
